// File: rtl/div_unit_if.sv
// Operand/result bundle between the control unit and the multicycle divider.
interface div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             DIV_control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             divStop;
    logic             divZero;
    logic             busy;

    modport master (
        output DIV_control, A, B,
        input  HI, LO, divStop, divZero, busy
    );

    modport slave (
        input  DIV_control, A, B,
        output HI, LO, divStop, divZero, busy
    );
endinterface

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient to LO, remainder to HI.
// Works on magnitudes and applies signs in FIX, so results truncate toward zero.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic       clk,
    input logic       reset,
    div_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_stop;
    logic             r_zero;
    logic             r_zero_pend;
    logic             r_busy;

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    always_comb begin
        w_abs_a  = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
        w_abs_b  = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;
        w_rem_sh = {r_rem, r_q[WIDTH-1]};
        // rem_sh < 2*divisor, so bit WIDTH of the difference is a valid sign.
        w_trial  = w_rem_sh - {1'b0, r_div};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_stop      <= 1'b0;
            r_zero      <= 1'b0;
            r_zero_pend <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_stop      <= 1'b0;
            // Divide-by-zero is flagged one cycle after the start edge.
            r_zero      <= r_zero_pend;
            r_zero_pend <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.DIV_control) begin
                        if (bus.B == '0) begin
                            r_zero_pend <= 1'b1;
                        end else begin
                            r_sign_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                            r_sign_r <= bus.A[WIDTH-1];
                            r_q      <= w_abs_a;
                            r_div    <= w_abs_b;
                            r_rem    <= '0;
                            r_count  <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_rem   <= w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_q     <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_lo    <= r_sign_q ? (~r_q + 1'b1) : r_q;
                    r_hi    <= r_sign_r ? (~r_rem + 1'b1) : r_rem;
                    r_stop  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.HI      = r_hi;
    assign bus.LO      = r_lo;
    assign bus.divStop = r_stop;
    assign bus.divZero = r_zero;
    assign bus.busy    = r_busy;
endmodule

// File: doc/div_unit.md
# div_unit

Multicycle signed 32-bit divider for the MIPS-subset datapath. It sits beside the ALU, takes operands from the A/B registers, and writes quotient to LO and remainder to HI for the HI/LO register path. The control unit starts it with `DIV_control` and waits on `divStop`, or on `divZero` for the divide-by-zero exception path.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; counter width = clog2(WIDTH)+1

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset
- `DIV_control`  in  1  start request, sampled on rising edge while IDLE
- `A`  in  WIDTH  dividend (two's complement)
- `B`  in  WIDTH  divisor (two's complement)
- `HI`  out  WIDTH  remainder, registered
- `LO`  out  WIDTH  quotient, registered
- `divStop`  out  1  one-cycle completion pulse; HI/LO valid while high
- `divZero`  out  1  one-cycle pulse: start requested with B == 0
- `busy`  out  1  high in RUN and FIX

## Operation
- State machine: IDLE → RUN → FIX → IDLE.
- IDLE with `DIV_control`=1 and B≠0:
  - latch sign_q = A[31]^B[31] and sign_r = A[31];
  - latch |A| into the quotient shift register and |B| into the divisor register;
  - clear the partial remainder and set count=0;
  - go to RUN.
- IDLE with `DIV_control`=1 and B==0: set `divZero`=1 for one cycle, stay IDLE. HI/LO unchanged; `divStop` not asserted.
- RUN, restoring division, one quotient bit per cycle:
  - {rem,q} shifted left 1;
  - trial = rem − divisor (WIDTH+1 bits);
  - if trial is non-negative: rem=trial and q[0]=1, else q[0]=0;
  - count++. After WIDTH iterations go to FIX.
- FIX:
  - LO = sign_q ? −q : q;
  - HI = sign_r ? −rem : rem;
  - set `divStop`=1 for one cycle and return to IDLE.
- Result semantics:
  - quotient truncates toward zero; remainder takes the dividend's sign;
  - A == q·B + r holds for all B≠0.
- Overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no flag raised. This is the natural result of the magnitude algorithm truncated to WIDTH.
- Magnitude of 0x80000000 is computed as an unsigned 0x80000000; the magnitude datapath is unsigned WIDTH bits.
- `DIV_control` while in RUN or FIX is ignored. The operation is not restarted and operands are not re-latched.
- A/B may change after the start edge without affecting the result.
- HI/LO hold their last values until the next FIX. They are never cleared by a divide-by-zero.

## Timing
- Reset (reset=0 at an edge), applied from any state, including mid-RUN:
  - state=IDLE, count=0;
  - HI=0, LO=0, `divStop`=0, `divZero`=0, `busy`=0.
  - An in-flight division is discarded and `divStop` never pulses for it.
- Let E0 be the edge sampling `DIV_control`=1 in IDLE.
  - `busy`=1 from E0 through E33.
  - Iterations occur at E1..E32.
  - FIX loads HI/LO and sets `divStop`=1 at E33; `divStop` clears at E34.
  - Latency: 33 cycles from start to `divStop`.
- A new start is accepted at E34 at the earliest. `DIV_control` held high continuously restarts at E34 with the then-current A/B.
- Divide-by-zero: `divZero`=1 from E1 to E2; `busy` stays 0.
- `divStop` and `divZero` are never high in the same cycle.

## Test plan
- A=100, B=7 → at E33: LO=14, HI=2, `divStop` high for exactly one cycle; `busy` high for E0..E33.
- A=−100 (0xFFFFFF9C), B=7 → LO=0xFFFFFFF2 (−14), HI=0xFFFFFFFE (−2). Repeat with B=−7: LO=14, HI=−2.
- Preload HI/LO via 100/7, then A=5, B=0 → `divZero` high E1..E2; HI=2, LO=14 unchanged; no `divStop`; `busy` stays 0.
- A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0. Also A=0x80000000, B=1 → LO=0x80000000, HI=0.
- Start 100/7, change A/B and pulse `DIV_control` at E10 → result still LO=14, HI=2 at E33, with no second operation started.
- Start 1000/3, drive reset=0 at E12 → HI=LO=0 and `busy`=0 after E12, and no `divStop` within 40 cycles. Then start 9/4 → LO=2, HI=1 at 33 cycles after the new start.
